// File: rtl/uart_pkg.sv
// Shared types, constants and parity helper for the uart_xcvr transceiver.
package uart_pkg;

  localparam int MAX_DATA_W = 16;
  localparam int MIN_LEN = 5;
  localparam logic IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_t;

  // XOR of the low len bits, inverted for odd parity.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                       input logic [4:0] len,
                                       input par_mode_t mode);
    logic p;
    p = (mode == PAR_ODD);
    for (int i = 0; i < MAX_DATA_W; i++)
      if (5'(i) < len) p = p ^ data[i];
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every div+1 clocks; new div applies at wrap.
module uart_baud_tick
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] div_q;

  assign tick = (count == div_q);

  // The period is re-sampled only at wrap so a div change never truncates a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      div_q <= '0;
    end else if (tick) begin
      count <= '0;
      div_q <= div;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex oversampling UART transceiver with valid/ready RX and error flags.
// Optional macro UART_LOOPBACK_EN adds a loopback input routing txd into RX.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OSR    = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_stop2,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              txd,
  input  logic              rxd,
`ifdef UART_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_overrun
);

  localparam int CNT_W = $clog2(OSR);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OSR / 2 - 1);
  localparam logic [4:0] LEN_MAX = 5'(DATA_W);
  localparam logic [4:0] LEN_MIN = 5'(MIN_LEN);

  logic       tick;
  logic [4:0] len_eff;
  logic       txd_int;
  logic       rx_in;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    len_eff = {1'b0, cfg_len};
    if (len_eff < LEN_MIN) len_eff = LEN_MIN;
    else if (len_eff > LEN_MAX) len_eff = LEN_MAX;
  end

`ifdef UART_LOOPBACK_EN
  assign txd   = loopback ? IDLE_LVL : txd_int;
  assign rx_in = loopback ? txd_int : rxd;
`else
  assign txd   = txd_int;
  assign rx_in = rxd;
`endif

  // ---------------- transmitter ----------------
  tx_state_t         tx_state, tx_state_n;
  logic [DATA_W-1:0] tx_shift;
  logic [4:0]        tx_len, tx_bit;
  logic [CNT_W-1:0]  tx_cnt;
  logic              tx_par_en, tx_par, tx_stop2;
  logic              tx_accept, tx_end;

  always_comb begin
    tx_state_n = tx_state;
    tx_accept  = 1'b0;
    tx_end     = tick && (tx_cnt == CNT_MAX);
    tx_ready   = (tx_state == TX_IDLE);
    tx_busy    = (tx_state != TX_IDLE);
    txd_int    = IDLE_LVL;
    case (tx_state)
      TX_IDLE: if (tx_valid) begin
        tx_accept  = 1'b1;
        tx_state_n = TX_START;
      end
      TX_START: begin
        txd_int = 1'b0;
        if (tx_end) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        txd_int = tx_shift[0];
        if (tx_end && tx_bit == tx_len - 5'd1)
          tx_state_n = tx_par_en ? TX_PARITY : TX_STOP1;
      end
      TX_PARITY: begin
        txd_int = tx_par;
        if (tx_end) tx_state_n = TX_STOP1;
      end
      TX_STOP1: if (tx_end) tx_state_n = tx_stop2 ? TX_STOP2 : TX_IDLE;
      TX_STOP2: if (tx_end) tx_state_n = TX_IDLE;
      default:  tx_state_n = TX_IDLE;
    endcase
  end

  // Frame settings are captured at accept so mid-frame config changes cannot corrupt the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_shift  <= '0;
      tx_len    <= LEN_MIN;
      tx_bit    <= '0;
      tx_cnt    <= '0;
      tx_par_en <= 1'b0;
      tx_par    <= 1'b0;
      tx_stop2  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      if (tx_accept) begin
        tx_shift  <= tx_data;
        tx_len    <= len_eff;
        tx_bit    <= '0;
        tx_cnt    <= '0;
        tx_par_en <= cfg_par_en;
        tx_par    <= calc_parity(MAX_DATA_W'(tx_data), len_eff, par_mode_t'(cfg_par_odd));
        tx_stop2  <= cfg_stop2;
      end else if (tick && tx_state != TX_IDLE) begin
        tx_cnt <= tx_end ? '0 : tx_cnt + 1'b1;
        if (tx_end && tx_state == TX_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= tx_bit + 5'd1;
        end
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t         rx_state, rx_state_n;
  logic              rx_s1, rx_s2, rx_s3;
  logic [DATA_W-1:0] rx_shift;
  logic [4:0]        rx_len, rx_bit;
  logic [CNT_W-1:0]  rx_cnt;
  logic              rx_par_en, rx_stop2, rx_perr_q;
  par_mode_t         rx_par_mode;
  logic              rx_start, rx_mid, rx_sample, rx_done, rx_done_ferr, rx_counting;

  always_comb begin
    rx_state_n   = rx_state;
    rx_start     = 1'b0;
    rx_done      = 1'b0;
    rx_done_ferr = 1'b0;
    rx_counting  = !(rx_state inside {RX_IDLE, RX_WAIT_HIGH});
    rx_mid       = (rx_state == RX_START) ? (rx_cnt == HALF_CNT) : (rx_cnt == CNT_MAX);
    rx_sample    = tick && rx_mid;
    case (rx_state)
      RX_IDLE: if (rx_s3 && !rx_s2) begin
        rx_start   = 1'b1;
        rx_state_n = RX_START;
      end
      RX_START: if (rx_sample) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA: if (rx_sample && rx_bit == rx_len - 5'd1)
        rx_state_n = rx_par_en ? RX_PARITY : RX_STOP1;
      RX_PARITY: if (rx_sample) rx_state_n = RX_STOP1;
      RX_STOP1: if (rx_sample) begin
        if (!rx_s2) begin
          rx_done      = 1'b1;
          rx_done_ferr = 1'b1;
          rx_state_n   = RX_WAIT_HIGH;
        end else if (rx_stop2) begin
          rx_state_n = RX_STOP2;
        end else begin
          rx_done    = 1'b1;
          rx_state_n = RX_IDLE;
        end
      end
      RX_STOP2: if (rx_sample) begin
        rx_done      = 1'b1;
        rx_done_ferr = !rx_s2;
        rx_state_n   = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx_s2) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // The third sync stage only exists to find the falling edge of the start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1       <= IDLE_LVL;
      rx_s2       <= IDLE_LVL;
      rx_s3       <= IDLE_LVL;
      rx_state    <= RX_IDLE;
      rx_shift    <= '0;
      rx_len      <= LEN_MIN;
      rx_bit      <= '0;
      rx_cnt      <= '0;
      rx_par_en   <= 1'b0;
      rx_par_mode <= PAR_EVEN;
      rx_stop2    <= 1'b0;
      rx_perr_q   <= 1'b0;
    end else begin
      rx_s1    <= rx_in;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_n;
      if (rx_start) begin
        rx_shift    <= '0;
        rx_len      <= len_eff;
        rx_bit      <= '0;
        rx_cnt      <= '0;
        rx_par_en   <= cfg_par_en;
        rx_par_mode <= par_mode_t'(cfg_par_odd);
        rx_stop2    <= cfg_stop2;
        rx_perr_q   <= 1'b0;
      end else if (tick && rx_counting) begin
        rx_cnt <= rx_mid ? '0 : rx_cnt + 1'b1;
        if (rx_mid && rx_state == RX_DATA) begin
          for (int i = 0; i < DATA_W; i++)
            if (5'(i) == rx_bit) rx_shift[i] <= rx_s2;
          rx_bit <= rx_bit + 5'd1;
        end
        if (rx_mid && rx_state == RX_PARITY)
          rx_perr_q <= rx_s2 ^ calc_parity(MAX_DATA_W'(rx_shift), rx_len, rx_par_mode);
      end
    end
  end

  // A completing frame only replaces the held word if that word is being consumed this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_done) begin
        if (!rx_valid || rx_ready) begin
          rx_valid      <= 1'b1;
          rx_data       <= rx_shift;
          rx_parity_err <= rx_perr_q;
          rx_frame_err  <= rx_done_ferr;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: table of TX->RX loopback frames plus bit-banged corner cases.
module tb_uart_xcvr;
  import uart_pkg::*;

  localparam int DATA_W = 8;
  localparam int OSR    = 16;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DIV_W-1:0]  div;
  logic [3:0]        cfg_len;
  logic              cfg_par_en, cfg_par_odd, cfg_stop2;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid, tx_ready, tx_busy, txd;
  logic              rxd;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, rx_ready, rx_parity_err, rx_frame_err, rx_overrun;
  logic              use_tb_rxd, tb_rxd;

  assign rxd = use_tb_rxd ? tb_rxd : txd;

  always #5 clk = ~clk;

  uart_xcvr #(.DATA_W(DATA_W), .OSR(OSR), .DIV_W(DIV_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .div           (div),
    .cfg_len       (cfg_len),
    .cfg_par_en    (cfg_par_en),
    .cfg_par_odd   (cfg_par_odd),
    .cfg_stop2     (cfg_stop2),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_busy       (tx_busy),
    .txd           (txd),
    .rxd           (rxd),
`ifdef UART_LOOPBACK_EN
    .loopback      (1'b0),
`endif
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
    logic [7:0] exp_data;
    int         exp_clks;
    int         par_pos;
    logic       exp_par_bit;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int ovr_count = 0;

  always @(negedge clk) if (rx_overrun) ovr_count++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setCfg(input logic [3:0] len, input logic par_en, input logic par_odd, input logic stop2);
    cfg_len     = len;
    cfg_par_en  = par_en;
    cfg_par_odd = par_odd;
    cfg_stop2   = stop2;
  endtask

  // Sends one word through TX, returns clocks from accept to tx_ready and mid-bit line samples.
  task automatic applyStimulus(input vec_t v, output int clks, output logic [15:0] line);
    for (int i = 0; i < 2000 && !tx_ready; i++) @(negedge clk);
    checkOutput("tx_idle_before_send", tx_ready, 1);
    @(negedge clk);
    setCfg(v.len, v.par_en, v.par_odd, v.stop2);
    tx_data  = v.data;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    clks = 0;
    line = '1;
    while (clks < 1000) begin
      @(posedge clk);
      clks++;
      #1;
      if (clks % 16 == 8 && clks / 16 < 16) line[clks / 16] = txd;
      if (tx_ready) break;
    end
  endtask

  task automatic waitRx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rx_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consumeRx();
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    checkOutput("rx_valid_cleared", rx_valid, 0);
  endtask

  task automatic driveBits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tb_rxd = bits[i];
      repeat (15) @(negedge clk);
    end
  endtask

  vec_t        vecs[6];
  int          clks;
  logic [15:0] line;
  bit          ok;
  int          ovr_base;
  logic        seen;

  initial begin
    vecs[0] = '{8'hA5, 4'd8,  1'b0, 1'b0, 1'b0, 8'hA5, 160, -1, 1'b0};
    vecs[1] = '{8'h55, 4'd7,  1'b1, 1'b1, 1'b1, 8'h55, 176,  8, 1'b1};
    vecs[2] = '{8'hFF, 4'd5,  1'b1, 1'b0, 1'b0, 8'h1F, 128,  6, 1'b1};
    vecs[3] = '{8'hC3, 4'd3,  1'b0, 1'b0, 1'b1, 8'h03, 128, -1, 1'b0};
    vecs[4] = '{8'h96, 4'd15, 1'b1, 1'b1, 1'b0, 8'h96, 176,  9, 1'b1};
    vecs[5] = '{8'h00, 4'd6,  1'b1, 1'b1, 1'b0, 8'h00, 144,  7, 1'b1};

    rst = 1'b1;
    div = '0;
    setCfg(4'd8, 1'b0, 1'b0, 1'b0);
    tx_data = '0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    use_tb_rxd = 1'b0;
    tb_rxd = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", txd, 1);
    checkOutput("reset_tx_ready", tx_ready, 1);
    checkOutput("reset_tx_busy", tx_busy, 0);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k], clks, line);
      checkOutput($sformatf("v%0d_tx_clks", k), clks, vecs[k].exp_clks);
      checkOutput($sformatf("v%0d_start_bit", k), line[0], 0);
      if (vecs[k].par_pos >= 0)
        checkOutput($sformatf("v%0d_parity_line", k), line[vecs[k].par_pos], vecs[k].exp_par_bit);
      waitRx(ok);
      checkOutput($sformatf("v%0d_rx_seen", k), ok, 1);
      checkOutput($sformatf("v%0d_rx_data", k), rx_data, vecs[k].exp_data);
      checkOutput($sformatf("v%0d_rx_perr", k), rx_parity_err, 0);
      checkOutput($sformatf("v%0d_rx_ferr", k), rx_frame_err, 0);
      consumeRx();
    end

    $display("[TB] inverted parity bit");
    use_tb_rxd = 1'b1;
    setCfg(4'd8, 1'b1, 1'b0, 1'b0);
    driveBits(32'h61E, 11);
    tb_rxd = 1'b1;
    waitRx(ok);
    checkOutput("perr_rx_seen", ok, 1);
    checkOutput("perr_rx_data", rx_data, 8'h0F);
    checkOutput("perr_flag", rx_parity_err, 1);
    checkOutput("perr_ferr", rx_frame_err, 0);
    consumeRx();

    $display("[TB] start glitch and line break");
    setCfg(4'd8, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    tb_rxd = 1'b0;
    repeat (4) @(negedge clk);
    tb_rxd = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("glitch_rx_idle", dut.rx_state, RX_IDLE);
    seen = 1'b0;
    repeat (40) @(negedge clk) seen |= rx_valid;
    checkOutput("glitch_no_valid", seen, 0);
    driveBits(32'h0B4, 10);
    waitRx(ok);
    checkOutput("ferr_rx_seen", ok, 1);
    checkOutput("ferr_rx_data", rx_data, 8'h5A);
    checkOutput("ferr_flag", rx_frame_err, 1);
    checkOutput("ferr_perr", rx_parity_err, 0);
    consumeRx();
    seen = 1'b0;
    repeat (64) @(negedge clk) seen |= rx_valid;
    checkOutput("break_no_valid", seen, 0);
    checkOutput("break_wait_high", dut.rx_state, RX_WAIT_HIGH);
    tb_rxd = 1'b1;
    repeat (32) @(negedge clk);
    checkOutput("break_released_idle", dut.rx_state, RX_IDLE);
    driveBits(32'h346, 10);
    tb_rxd = 1'b1;
    waitRx(ok);
    checkOutput("after_break_seen", ok, 1);
    checkOutput("after_break_data", rx_data, 8'hA3);
    checkOutput("after_break_ferr", rx_frame_err, 0);
    consumeRx();

    $display("[TB] overrun");
    use_tb_rxd = 1'b0;
    ovr_base = ovr_count;
    applyStimulus('{8'h11, 4'd8, 1'b0, 1'b0, 1'b0, 8'h11, 160, -1, 1'b0}, clks, line);
    checkOutput("ovr_first_clks", clks, 160);
    applyStimulus('{8'h22, 4'd8, 1'b0, 1'b0, 1'b0, 8'h22, 160, -1, 1'b0}, clks, line);
    checkOutput("ovr_second_clks", clks, 160);
    repeat (20) @(negedge clk);
    checkOutput("ovr_rx_valid", rx_valid, 1);
    checkOutput("ovr_rx_data", rx_data, 8'h11);
    checkOutput("ovr_pulse_count", ovr_count - ovr_base, 1);
    consumeRx();

    $display("[TB] reset mid-frame");
    @(negedge clk);
    setCfg(4'd8, 1'b0, 1'b0, 1'b0);
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (48) @(negedge clk);
    checkOutput("midframe_busy", tx_busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_txd", txd, 1);
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_tx_busy", tx_busy, 0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (300) @(negedge clk) seen |= rx_valid;
    checkOutput("rst_no_partial_word", seen, 0);
    applyStimulus('{8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 8'h3C, 160, -1, 1'b0}, clks, line);
    checkOutput("post_rst_clks", clks, 160);
    waitRx(ok);
    checkOutput("post_rst_seen", ok, 1);
    checkOutput("post_rst_data", rx_data, 8'h3C);
    checkOutput("post_rst_flags", {rx_parity_err, rx_frame_err}, 0);
    consumeRx();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
